// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings and the data-phase state type for the SRAM slave.
package ahblite_pkg;

    // htrans encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // hsize encodings (only up to a 32-bit word is meaningful here)
    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // hresp encodings
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Data-phase FSM states
    typedef enum logic [2:0] {
        ST_NONE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_READ   = 3'd2,
        ST_RSTALL = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } dp_state_t;

endpackage

// File: rtl/ahblite_sram_slave_if.sv
// Bus bundle for the AHB-Lite SRAM slave: AHB slave port plus SRAM request port.
interface ahblite_sram_slave_if #(
    parameter int AHB_AW = 32,
    parameter int AHB_DW = 32,
    parameter int MEM_AW = 10
);
    // AHB-Lite slave inputs
    logic              hsel_i;
    logic              hready_i;
    logic              hwrite_i;
    logic              hmastlock_i;
    logic [AHB_AW-1:0] haddr_i;
    logic [1:0]        htrans_i;
    logic [2:0]        hsize_i;
    logic [2:0]        hburst_i;
    logic [3:0]        hprot_i;
    logic [AHB_DW-1:0] hwdata_i;
    // AHB-Lite slave responses
    logic              hreadyout_o;
    logic              hresp_o;
    logic [AHB_DW-1:0] hrdata_o;
    // Synchronous SRAM request / response
    logic              sram_ce_o;
    logic              sram_we_o;
    logic [3:0]        sram_be_o;
    logic [MEM_AW-1:0] sram_addr_o;
    logic [31:0]       sram_wdata_o;
    logic [31:0]       sram_rdata_i;

    modport slave (
        input  hsel_i, hready_i, hwrite_i, hmastlock_i, haddr_i, htrans_i,
               hsize_i, hburst_i, hprot_i, hwdata_i, sram_rdata_i,
        output hreadyout_o, hresp_o, hrdata_o,
               sram_ce_o, sram_we_o, sram_be_o, sram_addr_o, sram_wdata_o
    );

    modport master (
        output hsel_i, hready_i, hwrite_i, hmastlock_i, haddr_i, htrans_i,
               hsize_i, hburst_i, hprot_i, hwdata_i, sram_rdata_i,
        input  hreadyout_o, hresp_o, hrdata_o,
               sram_ce_o, sram_we_o, sram_be_o, sram_addr_o, sram_wdata_o
    );
endinterface

// File: rtl/ahblite_be_gen.sv
// Big-endian byte-enable generation and alignment check for one AHB transfer.
module ahblite_be_gen
    import ahblite_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  logic [2:0] size,
    output logic [3:0] be,
    output logic       err
);

    logic [2:0] nbytes;
    logic [2:0] first_off;
    logic [2:0] end_off;

    // Transfer length in bytes and misalignment detection
    always_comb begin
        nbytes = 3'd0;
        err    = 1'b0;
        case (size)
            HSIZE_BYTE: nbytes = 3'd1;
            HSIZE_HALF: begin
                nbytes = 3'd2;
                err    = addr_lo[0];
            end
            HSIZE_WORD: begin
                nbytes = 3'd4;
                err    = (addr_lo != 2'b00);
            end
            default: err = 1'b1;
        endcase
    end

    assign first_off = {1'b0, addr_lo};
    assign end_off   = first_off + nbytes;

    // Lane gi carries byte offset 3-gi (offset 0 is the MSB lane).
    // A lane is enabled when its offset falls inside [first_off, end_off).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [2:0] LANE_OFF = 3'(3 - gi);
            assign be[gi] = !err && (LANE_OFF >= first_off) && (LANE_OFF < end_off);
        end
    endgenerate

endmodule

// File: rtl/ahblite_sram_slave.sv
// AHB-Lite slave in front of a synchronous single-port SRAM (1-cycle read latency).
// Writes are zero-wait (data lands in the data phase); reads are issued in the
// address phase so they are zero-wait too, except when the port is busy with a
// write data phase, in which case one stall cycle re-issues the read afterwards.
module ahblite_sram_slave
    import ahblite_pkg::*;
#(
    parameter int AHB_AW = 32,
    parameter int AHB_DW = 32,
    parameter int MEM_AW = 10
) (
    input  logic               clk,
    input  logic               rst,
    ahblite_sram_slave_if.slave bus
);

    dp_state_t         state_reg, state_next;
    logic [MEM_AW-1:0] addr_reg, addr_next;
    logic [3:0]        be_reg, be_next;

    logic [3:0]        be_addr;
    logic              size_err;
    logic [MEM_AW-1:0] word_addr;
    logic              can_accept;
    logic              take;
    logic              take_read_now;

    ahblite_be_gen u_be_gen (
        .addr_lo (bus.haddr_i[1:0]),
        .size    (bus.hsize_i),
        .be      (be_addr),
        .err     (size_err)
    );

    // Upper address bits are ignored, so the SRAM aliases across the AHB region
    assign word_addr = bus.haddr_i[MEM_AW+1:2];

    // RSTALL and ERR1 hold hreadyout low and never take a new address phase
    assign can_accept = (state_reg == ST_NONE)  || (state_reg == ST_WRITE) ||
                        (state_reg == ST_READ)  || (state_reg == ST_ERR2);

    assign take = !rst && can_accept && bus.hsel_i && bus.hready_i &&
                  ((bus.htrans_i == HTRANS_NONSEQ) || (bus.htrans_i == HTRANS_SEQ));

    // Legal read while the SRAM port is free: issue it right away from haddr
    assign take_read_now = take && !bus.hwrite_i && !size_err && (state_reg != ST_WRITE);

    // Next data-phase state and the address/byte-enable latch
    always_comb begin
        state_next = ST_NONE;
        addr_next  = addr_reg;
        be_next    = be_reg;
        if (state_reg == ST_RSTALL) begin
            state_next = ST_READ;
        end else if (state_reg == ST_ERR1) begin
            state_next = ST_ERR2;
        end else if (take) begin
            if (size_err) begin
                state_next = ST_ERR1;
            end else if (bus.hwrite_i) begin
                state_next = ST_WRITE;
                addr_next  = word_addr;
                be_next    = be_addr;
            end else if (state_reg == ST_WRITE) begin
                state_next = ST_RSTALL;
                addr_next  = word_addr;
                be_next    = be_addr;
            end else begin
                state_next = ST_READ;
            end
        end
    end

    // State and latched request registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_NONE;
            addr_reg  <= '0;
            be_reg    <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            be_reg    <= be_next;
        end
    end

    // SRAM request: data-phase write, stalled read, or address-phase read
    always_comb begin
        bus.sram_ce_o    = 1'b0;
        bus.sram_we_o    = 1'b0;
        bus.sram_addr_o  = addr_reg;
        bus.sram_be_o    = be_reg;
        bus.sram_wdata_o = bus.hwdata_i;
        if (!rst) begin
            if (state_reg == ST_WRITE) begin
                bus.sram_ce_o = 1'b1;
                bus.sram_we_o = 1'b1;
            end else if (state_reg == ST_RSTALL) begin
                bus.sram_ce_o = 1'b1;
            end else if (take_read_now) begin
                bus.sram_ce_o   = 1'b1;
                bus.sram_addr_o = word_addr;
                bus.sram_be_o   = be_addr;
            end
        end
    end

    // AHB response decoded from the registered state
    always_comb begin
        bus.hreadyout_o = !((state_reg == ST_RSTALL) || (state_reg == ST_ERR1));
        bus.hresp_o     = ((state_reg == ST_ERR1) || (state_reg == ST_ERR2)) ? HRESP_ERROR
                                                                            : HRESP_OKAY;
        bus.hrdata_o    = (state_reg == ST_READ) ? bus.sram_rdata_i : '0;
    end

    // Inputs that carry no meaning for a plain SRAM target
    logic unused_bits;
    assign unused_bits = ^{bus.hburst_i, bus.hprot_i, bus.hmastlock_i,
                           bus.haddr_i[AHB_AW-1:MEM_AW+2]};

endmodule

// File: tb/tb_ahblite_sram_slave.sv
// Directed, table-driven bench for ahblite_sram_slave with a behavioural SRAM.
`timescale 1ns/1ps
module tb_ahblite_sram_slave;
    import ahblite_pkg::*;

    localparam int MEM_AW = 10;

    logic clk;
    logic rst;

    ahblite_sram_slave_if #(.AHB_AW(32), .AHB_DW(32), .MEM_AW(MEM_AW)) bus ();

    ahblite_sram_slave #(.AHB_AW(32), .AHB_DW(32), .MEM_AW(MEM_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single slave: the interconnect's hready is this slave's hreadyout
    assign bus.hready_i = bus.hreadyout_o;

    // Behavioural synchronous SRAM, one cycle read latency
    logic [31:0] mem [0:(1<<MEM_AW)-1];
    initial begin
        for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = 32'h0;
        bus.sram_rdata_i = 32'h0;
    end
    always @(posedge clk) begin
        if (bus.sram_ce_o) begin
            if (bus.sram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.sram_be_o[b]) mem[bus.sram_addr_o][b*8 +: 8] <= bus.sram_wdata_o[b*8 +: 8];
            end else begin
                bus.sram_rdata_i <= mem[bus.sram_addr_o];
            end
        end
    end

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        e_rdy;
        logic        e_resp;
        logic [31:0] e_rdata;
        logic        e_ce;
        logic        e_we;
        logic [3:0]  e_be;
        logic [9:0]  e_saddr;
    } vec_t;

    vec_t vecs[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic vec_t mk(logic sel, logic [1:0] trans, logic wr, logic [2:0] size,
                                logic [31:0] addr, logic [31:0] wdata,
                                logic e_rdy, logic e_resp, logic [31:0] e_rdata,
                                logic e_ce, logic e_we, logic [3:0] e_be, logic [9:0] e_saddr);
        vec_t v;
        v.sel = sel; v.trans = trans; v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata;
        v.e_rdy = e_rdy; v.e_resp = e_resp; v.e_rdata = e_rdata;
        v.e_ce = e_ce; v.e_we = e_we; v.e_be = e_be; v.e_saddr = e_saddr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        bus.hsel_i   = sel;
        bus.htrans_i = trans;
        bus.hwrite_i = wr;
        bus.hsize_i  = size;
        bus.haddr_i  = addr;
        bus.hwdata_i = wdata;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " rdy"},   32'(bus.hreadyout_o), 32'd1);
        chk({tag, " resp"},  32'(bus.hresp_o),     32'd0);
        chk({tag, " rdata"}, bus.hrdata_o,         32'd0);
        chk({tag, " ce"},    32'(bus.sram_ce_o),   32'd0);
        chk({tag, " we"},    32'(bus.sram_we_o),   32'd0);
    endtask

    initial begin
        // Vector table: inputs driven for one cycle, expectations for that same cycle
        //            sel trans          wr   size        addr          wdata         rdy  resp rdata         ce   we   be       saddr
        vecs.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10,   32'h0,        1, 0, 32'h0,        0, 0, 4'h0,    10'd0));
        vecs.push_back(mk(1, HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,    32'hDEADBEEF, 1, 0, 32'h0,        1, 1, 4'hF,    10'd4));
        vecs.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10,   32'h0,        1, 0, 32'h0,        1, 0, 4'h0,    10'd4));
        vecs.push_back(mk(1, HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,    32'h0,        1, 0, 32'hDEADBEEF, 0, 0, 4'h0,    10'd0));
        vecs.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h20,   32'h0,        1, 0, 32'h0,        0, 0, 4'h0,    10'd0));
        vecs.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h20,   32'h11223344, 1, 0, 32'h0,        1, 1, 4'hF,    10'd8));
        vecs.push_back(mk(1, HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,    32'h0,        0, 0, 32'h0,        1, 0, 4'h0,    10'd8));
        vecs.push_back(mk(1, HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,    32'h0,        1, 0, 32'h11223344, 0, 0, 4'h0,    10'd0));
        vecs.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h21,   32'h0,        1, 0, 32'h0,        0, 0, 4'h0,    10'd0));
        vecs.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h20,   32'h00AB0000, 1, 0, 32'h0,        1, 1, 4'b0100, 10'd8));
        vecs.push_back(mk(1, HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,    32'h0,        0, 0, 32'h0,        1, 0, 4'h0,    10'd8));
        vecs.push_back(mk(1, HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,    32'h0,        1, 0, 32'h11AB3344, 0, 0, 4'h0,    10'd0));
        vecs.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h22,   32'h0,        1, 0, 32'h0,        0, 0, 4'h0,    10'd0));
        vecs.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_HALF, 32'h23,   32'h0,        0, 1, 32'h0,        0, 0, 4'h0,    10'd0));
        vecs.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_HALF, 32'h23,   32'h0,        1, 1, 32'h0,        0, 0, 4'h0,    10'd0));
        vecs.push_back(mk(1, HTRANS_NONSEQ, 0, 3'd3,       32'h20,   32'h0,        0, 1, 32'h0,        0, 0, 4'h0,    10'd0));
        vecs.push_back(mk(1, HTRANS_NONSEQ, 0, 3'd3,       32'h20,   32'h0,        1, 1, 32'h0,        0, 0, 4'h0,    10'd0));
        vecs.push_back(mk(1, HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,    32'h0,        0, 1, 32'h0,        0, 0, 4'h0,    10'd0));
        vecs.push_back(mk(1, HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,    32'h0,        1, 1, 32'h0,        0, 0, 4'h0,    10'd0));
        vecs.push_back(mk(1, HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,    32'h0,        1, 0, 32'h0,        0, 0, 4'h0,    10'd0));
        vecs.push_back(mk(1, HTRANS_IDLE,   1, HSIZE_WORD, 32'h20,   32'h0,        1, 0, 32'h0,        0, 0, 4'h0,    10'd0));
        vecs.push_back(mk(1, HTRANS_BUSY,   0, HSIZE_WORD, 32'h20,   32'h0,        1, 0, 32'h0,        0, 0, 4'h0,    10'd0));
        vecs.push_back(mk(0, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h20,   32'h0,        1, 0, 32'h0,        0, 0, 4'h0,    10'd0));
        vecs.push_back(mk(1, HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,    32'h0,        1, 0, 32'h0,        0, 0, 4'h0,    10'd0));
        vecs.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10,   32'h0,        1, 0, 32'h0,        1, 0, 4'h0,    10'd4));
        vecs.push_back(mk(1, HTRANS_SEQ,    0, HSIZE_HALF, 32'h20,   32'h0,        1, 0, 32'hDEADBEEF, 1, 0, 4'h0,    10'd8));
        vecs.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h12,   32'h0,        1, 0, 32'h11AB3344, 0, 0, 4'h0,    10'd0));
        vecs.push_back(mk(1, HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,    32'h0000CAFE, 1, 0, 32'h0,        1, 1, 4'b0011, 10'd4));
        vecs.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h1010, 32'h0,        1, 0, 32'h0,        1, 0, 4'h0,    10'd4));
        vecs.push_back(mk(1, HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,    32'h0,        1, 0, 32'hDEADCAFE, 0, 0, 4'h0,    10'd0));

        // Reset and idle bus
        rst = 1'b1;
        bus.hmastlock_i = 1'b0;
        bus.hburst_i    = 3'b000;
        bus.hprot_i     = 4'b0011;
        drive(0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
        #12;
        chk_reset_vals("por");
        #10;
        rst = 1'b0;

        // Table-driven sequence
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            drive(vecs[i].sel, vecs[i].trans, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata);
            @(negedge clk);
            $display("vec %0d: sel=%b trans=%b wr=%b size=%0d addr=%h | rdy=%b resp=%b rdata=%h ce=%b we=%b be=%b saddr=%0d",
                     i, vecs[i].sel, vecs[i].trans, vecs[i].wr, vecs[i].size, vecs[i].addr,
                     bus.hreadyout_o, bus.hresp_o, bus.hrdata_o, bus.sram_ce_o, bus.sram_we_o,
                     bus.sram_be_o, bus.sram_addr_o);
            chk($sformatf("v%0d rdy", i),   32'(bus.hreadyout_o), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d resp", i),  32'(bus.hresp_o),     32'(vecs[i].e_resp));
            chk($sformatf("v%0d rdata", i), bus.hrdata_o,         vecs[i].e_rdata);
            chk($sformatf("v%0d ce", i),    32'(bus.sram_ce_o),   32'(vecs[i].e_ce));
            chk($sformatf("v%0d we", i),    32'(bus.sram_we_o),   32'(vecs[i].e_we));
            if (vecs[i].e_ce)
                chk($sformatf("v%0d saddr", i), 32'(bus.sram_addr_o), 32'(vecs[i].e_saddr));
            if (vecs[i].e_ce && vecs[i].e_we) begin
                chk($sformatf("v%0d be", i),    32'(bus.sram_be_o), 32'(vecs[i].e_be));
                chk($sformatf("v%0d wdata", i), bus.sram_wdata_o,   vecs[i].wdata);
            end
        end

        // Reset pulsed during RSTALL: write 0x20 lands, stalled read is abandoned
        @(posedge clk); #1; drive(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h20, 32'h0);
        @(posedge clk); #1; drive(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h20, 32'h55667788);
        @(posedge clk); #1; drive(1, HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,  32'h0);
        @(negedge clk);
        $display("rstall: rdy=%b ce=%b", bus.hreadyout_o, bus.sram_ce_o);
        chk("rstall rdy", 32'(bus.hreadyout_o), 32'd0);
        chk("rstall ce",  32'(bus.sram_ce_o),   32'd1);
        #1 rst = 1'b1;
        #1 chk_reset_vals("async rst");
        @(posedge clk); #1;
        chk_reset_vals("held rst");
        @(negedge clk); #2 rst = 1'b0;
        @(posedge clk); #1; drive(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h20, 32'h0);
        @(negedge clk);
        chk("post-rst read ce",    32'(bus.sram_ce_o),   32'd1);
        chk("post-rst read saddr", 32'(bus.sram_addr_o), 32'd8);
        @(posedge clk); #1; drive(1, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
        @(negedge clk);
        $display("post-rst read 0x20: rdy=%b rdata=%h", bus.hreadyout_o, bus.hrdata_o);
        chk("post-rst read rdy",   32'(bus.hreadyout_o), 32'd1);
        chk("post-rst read rdata", bus.hrdata_o,         32'h55667788);

        // Reset during a pending WRITE data phase: the write must not land
        @(posedge clk); #1; drive(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h24, 32'h0);
        @(posedge clk); #1; drive(1, HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,  32'h99999999);
        @(negedge clk);
        chk("pend wr ce", 32'(bus.sram_ce_o), 32'd1);
        #1 rst = 1'b1;
        #1 chk_reset_vals("wr rst");
        @(posedge clk); #1;
        @(negedge clk); #2 rst = 1'b0;
        @(posedge clk); #1; drive(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h24, 32'h0);
        @(posedge clk); #1; drive(1, HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,  32'h0);
        @(negedge clk);
        $display("read 0x24 after aborted write: rdata=%h", bus.hrdata_o);
        chk("aborted wr rdata", bus.hrdata_o, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ahblite_sram_slave.md
AHBLITE_SRAM_SLAVE -- requirements
Module: ahblite_sram_slave

Interface
REQ-001 Parameter AHB_AW, 32, AHB address width.
REQ-002 Parameter AHB_DW, 32, AHB data width; only 32 is supported.
REQ-003 Parameter MEM_AW, 10, SRAM word-address width.
REQ-004 Port clk input 1: the single clock; all state is on the rising edge.
REQ-005 Port rst input 1: reset, asynchronous and active-high.
REQ-006 Ports hsel_i, hready_i, hwrite_i, hmastlock_i input 1 each; haddr_i input AHB_AW; htrans_i input 2; hsize_i input 3; hburst_i input 3; hprot_i input 4; hwdata_i input AHB_DW: standard AHB-Lite slave inputs from one interconnect slave port.
REQ-007 Ports hreadyout_o output 1, hresp_o output 1 (0=OKAY, 1=ERROR), hrdata_o output AHB_DW: AHB-Lite slave responses.
REQ-008 Ports sram_ce_o output 1, sram_we_o output 1, sram_be_o output 4, sram_addr_o output MEM_AW, sram_wdata_o output 32: synchronous single-port SRAM request.
REQ-009 Port sram_rdata_i input 32: SRAM read data, valid one clk after a read request (ce=1, we=0).

Function
REQ-010 An address phase is accepted only when hsel_i=1, hready_i=1 and htrans_i is NONSEQ or SEQ; IDLE and BUSY get a zero-wait OKAY and no SRAM access.
REQ-011 hburst_i, hprot_i and hmastlock_i are ignored.
REQ-012 An accepted transfer is in error when hsize_i>2, when hsize_i=1 and haddr_i[0]=1, or when hsize_i=2 and haddr_i[1:0]!=0.
REQ-013 SRAM word address = haddr[MEM_AW+1:2]; upper bits are ignored and addresses alias.
REQ-014 Lane mapping is big-endian: byte offset 0 maps to bits 31:24 (be[3]), offset 3 to bits 7:0 (be[0]). Byte enables are be=4'b1000>>off for bytes, 4'b1100>>off for halfwords, 4'b1111 for words.
REQ-015 The data-phase FSM has states NONE, WRITE, READ, RSTALL, ERR1 and ERR2.
REQ-016 In NONE, hreadyout_o=1 and hresp_o=0.
REQ-017 Write, accepted and legal: go to WRITE, latching the address and byte enables. In the WRITE cycle, drive sram_ce_o=1, sram_we_o=1, the latched address and be, and sram_wdata_o=hwdata_i, with hreadyout_o=1 (zero wait).
REQ-018 Read, accepted and legal, while the state is not WRITE: drive sram_ce_o=1 and sram_we_o=0 combinationally in the address-phase cycle from haddr_i, then go to READ. READ gives hreadyout_o=1 and hrdata_o=sram_rdata_i.
REQ-019 Read accepted while the state is WRITE (port conflict): go to RSTALL with the address latched. RSTALL gives hreadyout_o=0 and issues the SRAM read from the latched address, then goes to READ. The write therefore lands first, and a same-address read returns the new data.
REQ-020 Illegal transfer: no SRAM access. ERR1 gives hreadyout_o=0, hresp_o=1; ERR2 gives hreadyout_o=1, hresp_o=1. After ERR2 the FSM returns to NONE or accepts the next address phase.
REQ-021 From WRITE, READ or ERR2, the next state follows the address phase accepted in the same cycle, else NONE. RSTALL and ERR1 never accept an address phase.
REQ-022 hrdata_o=0 in every state other than READ.
REQ-023 sram_ce_o=0 and sram_we_o=0 whenever no access is defined above. sram_be_o, sram_addr_o and sram_wdata_o are don't-care while sram_ce_o=0.

Reset
REQ-024 While rst=1: FSM=NONE, hreadyout_o=1, hresp_o=0, hrdata_o=0, sram_ce_o=0, sram_we_o=0, and the latched address and be are 0.
REQ-025 Reset asserted mid-transfer abandons it immediately, including any pending WRITE or RSTALL; no SRAM access occurs while rst=1.

Structure
REQ-026 Shared package ahblite_pkg holds: the htrans encodings (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11), the hsize encodings, the hresp OKAY/ERROR constants, and the data-phase FSM state enum.
REQ-027 Byte-enable and alignment-check logic sits in one combinational sub-module, ahblite_be_gen.

Verification
REQ-028 Scenario: word write 0xDEADBEEF to 0x10, followed by an idle, then a word read of 0x10 -> zero wait on both; hrdata_o=0xDEADBEEF; write cycle sram_be_o=4'b1111, sram_addr_o=4.
REQ-029 Scenario: write 0x11223344 to 0x20, then a back-to-back word read of 0x20 -> exactly one cycle hreadyout_o=0 (RSTALL); hrdata_o=0x11223344.
REQ-030 Scenario: byte write of 0xAB at 0x21 with hwdata_i=0x00AB0000 -> sram_be_o=4'b0100; a following word read of 0x20 returns 0x11AB3344.
REQ-031 Scenario: word read at 0x22, then halfword at 0x23, then hsize=3 -> each gives a two-cycle ERROR (hreadyout 0 then 1, hresp 1 both cycles) and sram_ce_o stays 0.
REQ-032 Scenario: IDLE/BUSY with hsel_i=1, then NONSEQ with hsel_i=0 -> hreadyout_o=1, hresp_o=0, sram_ce_o=0 throughout.
REQ-033 Scenario: rst pulsed during RSTALL -> outputs reach their reset values asynchronously; the next read of 0x20 after reset completes normally.
